// File: rtl/snap_adc0_capture_ctrl.sv
// ADC0 snap capture controller: arm/trigger/capture FSM writing qualified samples to the snap BRAM.
// Optional trigger cycle stamp enabled by defining SNAP_ADC0_TRIG_TIMESTAMP_EN.
module snap_adc0_capture_ctrl #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 64
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic [31:0]       ctrl_in,
    input  logic              trig_in,
    input  logic              we_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_data,
    output logic              bram_we,
    output logic [31:0]       status_out,
    output logic [31:0]       trig_time
);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    localparam logic [ADDR_W:0] FULL    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    state_t          state, state_n;
    logic [ADDR_W:0] count, count_n, count_inc;
    logic            wrapped, wrapped_n;
    logic            arm_q, stop_q;
    logic            arm_edge, stop_edge;
    logic            trig_imm, circ;
    logic            wr;
    logic [31:0]     status_n;
    logic            ctrl_unused;

    assign arm_edge    = ctrl_in[0] & ~arm_q;
    assign stop_edge   = ctrl_in[3] & ~stop_q;
    assign trig_imm    = ctrl_in[1];
    assign circ        = ctrl_in[2];
    assign count_inc   = count + CNT_ONE;
    assign ctrl_unused = ^ctrl_in[31:4];

    always_comb begin
        state_n   = state;
        count_n   = count;
        wrapped_n = wrapped;
        wr        = 1'b0;
        if (arm_edge) begin
            state_n   = ARMED;
            count_n   = '0;
            wrapped_n = 1'b0;
        end else begin
            unique case (state)
                ARMED: begin
                    // count is zero while armed, so the trigger sample lands at address 0
                    if (we_in && (trig_imm || trig_in)) begin
                        wr      = 1'b1;
                        state_n = CAPTURE;
                        count_n = CNT_ONE;
                    end
                end
                CAPTURE: begin
                    if (circ && stop_edge) begin
                        state_n = DONE;
                    end else if (we_in) begin
                        wr = 1'b1;
                        if (count_inc == FULL) begin
                            if (circ) begin
                                count_n   = '0;
                                wrapped_n = 1'b1;
                            end else begin
                                count_n = count_inc;
                                state_n = DONE;
                            end
                        end else begin
                            count_n = count_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Status is built from next-state values so it lines up with the bram_we it describes
    always_comb begin
        status_n             = '0;
        status_n[31]         = (state_n == DONE);
        status_n[30]         = (state_n == CAPTURE);
        status_n[29]         = (state_n == ARMED);
        status_n[28]         = wrapped_n;
        status_n[ADDR_W:0]   = count_n;
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state      <= IDLE;
            count      <= '0;
            wrapped    <= 1'b0;
            arm_q      <= 1'b0;
            stop_q     <= 1'b0;
            bram_we    <= 1'b0;
            bram_addr  <= '0;
            bram_data  <= '0;
            status_out <= '0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            wrapped    <= wrapped_n;
            arm_q      <= ctrl_in[0];
            stop_q     <= ctrl_in[3];
            bram_we    <= wr;
            status_out <= status_n;
            if (wr) begin
                bram_addr <= count[ADDR_W-1:0];
                bram_data <= data_in;
            end
        end
    end

`ifdef SNAP_ADC0_TRIG_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic        trig_hit;

    assign trig_hit = (state == ARMED) && !arm_edge && we_in && (trig_imm || trig_in);

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            ts_cnt    <= '0;
            trig_time <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (trig_hit) begin
                trig_time <= ts_cnt;
            end
        end
    end
`else
    assign trig_time = '0;
`endif

endmodule
